bcd_tick_counter_mux: RTL and testbench



---
 rtl/bcd_tick_counter_mux.sv | 176 +++++++++++++++++
 tb/tb_bcd_tick_counter_mux.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_tick_counter_mux.sv
// N-digit BCD up/down tick counter with time-multiplexed 7-segment output.
// Optional leading-zero blanking: define BCD_TICK_LZ_BLANK_EN.
module bcd_tick_counter_mux #(
    parameter int TICK_DIV   = 100000000,
    parameter int SCAN_DIV   = 100000,
    parameter int NUM_DIGITS = 4,
    parameter int MAX_VAL    = 9999
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    tick,
    output logic                    wrap,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [PW-1:0] psc;
    logic [SW-1:0] sc;
    logic [IW-1:0] idx;
    logic          lv_ok;
    logic          step_wrap;
    logic [W-1:0]  step_val;
    logic [3:0]    dig;
    logic          blank;

    // With every digit <= 9, BCD order matches plain unsigned order.
    always_comb begin
        lv_ok = (load_val <= MAX_BCD);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) lv_ok = 1'b0;
        end
    end

    always_comb begin
        step_wrap = up ? (count == MAX_BCD) : (count == '0);
        if (step_wrap) step_val = up ? '0 : MAX_BCD;
        else           step_val = up ? bcd_inc(count) : bcd_dec(count);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc   <= '0;
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (load) begin
            psc   <= '0;
            count <= lv_ok ? load_val : MAX_BCD;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (en && psc == PW'(TICK_DIV - 1)) begin
            psc   <= '0;
            count <= step_val;
            tick  <= 1'b1;
            wrap  <= step_wrap;
        end else begin
            if (en) psc <= psc + PW'(1);
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc  <= '0;
            idx <= '0;
        end else if (sc == SW'(SCAN_DIV - 1)) begin
            sc  <= '0;
            idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            sc <= sc + SW'(1);
        end
    end

    always_comb begin
        dig = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx) dig = count[4*i +: 4];
        end
    end

`ifdef BCD_TICK_LZ_BLANK_EN
    // Walk down from the top digit; blank while everything above is zero.
    always_comb begin
        logic hi_zero;
        hi_zero = 1'b1;
        blank   = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            hi_zero = hi_zero && (count[4*i +: 4] == 4'd0);
            if (IW'(i) == idx) blank = hi_zero;
        end
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        case (dig)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        if (blank) seg = 7'b1111111;
    end

    assign an = ~(NUM_DIGITS'(1) << idx);

endmodule

// File: tb/tb_bcd_tick_counter_mux.sv
// Bench for bcd_tick_counter_mux: segment table plus cycle scoreboard
// fed by a decimal reference model (TICK_DIV=4, SCAN_DIV=2, 2 digits, 59).
module tb_bcd_tick_counter_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tick, wrap;
    logic [6:0] seg;
    logic [1:0] an;
    bit         clk_run = 1'b0;

    bcd_tick_counter_mux #(
        .TICK_DIV(4), .SCAN_DIV(2), .NUM_DIGITS(2), .MAX_VAL(59)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tick(tick), .wrap(wrap),
        .seg(seg), .an(an)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct {
        logic       e;
        logic       u;
        logic       l;
        logic [7:0] lv;
        int         n;
        logic [7:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [7:0] cnt;
        logic       tick;
        logic       wrap;
        logic [1:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t       sb[$];
    vec_t       tbl[15];
    logic [6:0] segtab[10];
    int n_vec = 0;
    int n_err = 0;
    int m_psc, m_cnt, m_sc, m_idx;
    bit m_tick, m_wrap;
    int wrap_seen;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_psc = 0; m_cnt = 0; m_sc = 0; m_idx = 0;
        m_tick = 0; m_wrap = 0;
    endtask

    task automatic cyc(input logic e, input logic u, input logic l,
                       input logic [7:0] lv);
        exp_t x;
        exp_t g;
        int v;
        int d;
        en = e; up = u; load = l; load_val = lv;
        if (l) begin
            m_psc = 0; m_tick = 0; m_wrap = 0;
            v = int'(lv[7:4]) * 10 + int'(lv[3:0]);
            if (lv[7:4] > 4'd9 || lv[3:0] > 4'd9 || v > 59) m_cnt = 59;
            else m_cnt = v;
        end else if (e && m_psc == 3) begin
            m_psc = 0; m_tick = 1;
            if (u) begin
                m_wrap = (m_cnt == 59);
                m_cnt  = m_wrap ? 0 : m_cnt + 1;
            end else begin
                m_wrap = (m_cnt == 0);
                m_cnt  = m_wrap ? 59 : m_cnt - 1;
            end
        end else begin
            if (e) m_psc++;
            m_tick = 0; m_wrap = 0;
        end
        if (m_sc == 1) begin
            m_sc = 0; m_idx = 1 - m_idx;
        end else begin
            m_sc++;
        end
        x.cnt  = {4'(m_cnt / 10), 4'(m_cnt % 10)};
        x.tick = m_tick;
        x.wrap = m_wrap;
        x.an   = (m_idx == 1) ? 2'b01 : 2'b10;
        d      = (m_idx == 1) ? m_cnt / 10 : m_cnt % 10;
        x.seg  = segtab[d];
`ifdef BCD_TICK_LZ_BLANK_EN
        if (m_idx == 1 && m_cnt < 10) x.seg = 7'b1111111;
`endif
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk("count", 32'(count), 32'(g.cnt));
            chk("tick", 32'(tick), 32'(g.tick));
            chk("wrap", 32'(wrap), 32'(g.wrap));
            chk("an", 32'(an), 32'(g.an));
            chk("seg", 32'(seg), 32'(g.seg));
        end
        if (wrap) wrap_seen++;
    endtask

    task automatic reset_check(input string nm);
        chk({nm, "_count"}, 32'(count), 32'h00);
        chk({nm, "_tick"}, 32'(tick), 32'd0);
        chk({nm, "_wrap"}, 32'(wrap), 32'd0);
        chk({nm, "_an"}, 32'(an), 32'b10);
        chk({nm, "_seg"}, 32'(seg), 32'b1000000);
    endtask

    initial begin
        segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                   7'b0000000, 7'b0010000};
        //          en    up    load  lv     n    count after
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 240, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 12,  8'h57};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 28,  8'h50};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 4,   8'h49};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 3,   8'h49};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h37, 1,   8'h37};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 4,   8'h38};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h7A, 1,   8'h59};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 2,   8'h59};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 10,  8'h59};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 2,   8'h00};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h42, 1,   8'h42};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 8,   8'h42};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h65, 1,   8'h59};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 8'h05, 6,   8'h05};

        en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        rst = 1'b1;
        #1;
        reset_check("por");
        rst = 1'b0;
        model_reset();
        clk_run = 1'b1;

        wrap_seen = 0;
        foreach (tbl[k]) begin
            for (int c = 0; c < tbl[k].n; c++)
                cyc(tbl[k].e, tbl[k].u, tbl[k].l, tbl[k].lv);
            chk($sformatf("seg%0d_end", k), 32'(count), 32'(tbl[k].exp_cnt));
            if (k == 0) chk("up_wraps", 32'(wrap_seen), 32'd1);
        end

        // Run up to a tick, then reset with the clock parked.
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1, 1'b0, 8'h00);
        chk("pre_rst_tick", 32'(tick), 32'd1);
        chk("pre_rst_count", 32'(count), 32'h06);
        clk_run = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        reset_check("mid_rst");
        #2;
        rst = 1'b0;
        model_reset();
        clk_run = 1'b1;
        for (int c = 0; c < 8; c++) cyc(1'b1, 1'b1, 1'b0, 8'h00);
        chk("post_rst_count", 32'(count), 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
